sampler_arbiter: RTL and testbench
==================================

SAMPLER_ARBITER -- requirements
Module: sampler_arbiter

Interface
REQ-001 Parameter NREQ, default 3, SHALL set the number of requesters sharing one poly_uniform engine.
REQ-002 Parameter TIMEOUT, default 4096, SHALL set the max cycles a grant may wait for eng_done.
REQ-003 clock  input  1  SHALL be the single clock; all state SHALL be on its rising edge.
REQ-004 reset  input  1  SHALL be an asynchronous, active-low reset.
REQ-005 req  input  NREQ  SHALL carry the per-requester level request, held until rsp_done or rsp_err.
REQ-006 req_seed  input  256*NREQ  SHALL carry the per-requester rho slices; requester k uses bits [256k+255:256k].
REQ-007 req_nonce  input  16*NREQ  SHALL carry the per-requester nonces; requester k uses bits [16k+15:16k].
REQ-008 gnt  output  NREQ  SHALL be one-hot (or zero) and mark the current engine owner.
REQ-009 rsp_done  output  NREQ  SHALL give a one-cycle pulse to the owner when the engine result is valid.
REQ-010 rsp_err  output  NREQ  SHALL give a one-cycle pulse to the owner on timeout.
REQ-011 eng_start  output  1  SHALL drive the poly_uniform start level.
REQ-012 eng_seed  output  256  SHALL drive the seed latched for the owner.
REQ-013 eng_nonce  output  16  SHALL drive the nonce latched for the owner.
REQ-014 eng_done  input  1  SHALL be the poly_uniform done flag; requesters read a_out directly from the engine.

Function
REQ-015 The FSM SHALL have the states IDLE, BUSY and RELEASE.
REQ-016 IDLE: with any req bit high, the block SHALL select the winner round-robin starting at index ptr.
- It SHALL register owner, eng_seed and eng_nonce from that requester.
- It SHALL set gnt[owner]=1 and eng_start=1, and go to BUSY on the next edge.
- Latency from req to eng_start SHALL be exactly 1 cycle.
REQ-017 On each grant, ptr SHALL update to (owner+1) mod NREQ and wrap from NREQ-1 to 0.
REQ-018 BUSY: eng_start SHALL stay 1 and eng_seed/eng_nonce SHALL stay stable.
- Changes on req_seed or req_nonce during BUSY SHALL be ignored.
REQ-019 BUSY with eng_done=1:
- rsp_done[owner] SHALL pulse for 1 cycle (registered, on the next edge).
- eng_start SHALL drop to 0, gnt SHALL clear, and the FSM SHALL go to RELEASE.
REQ-020 RELEASE: eng_start=0 for exactly 1 cycle so the engine re-arms, then the FSM SHALL return to IDLE.
- Back-to-back grants SHALL therefore be spaced at least 2 cycles apart (done edge to next eng_start).
REQ-021 A timeout counter SHALL clear on entry to BUSY and increment each BUSY cycle.
- If it reaches TIMEOUT-1 with eng_done=0, rsp_err[owner] SHALL pulse 1 cycle and the FSM SHALL go to RELEASE.
- rsp_done SHALL NOT pulse for that grant.
REQ-022 eng_done and timeout in the same cycle: eng_done SHALL win (rsp_done, no rsp_err).
REQ-023 If the owner drops req during BUSY, the grant SHALL still run to completion and rsp_done/rsp_err SHALL still pulse.
REQ-024 eng_done seen in IDLE or RELEASE SHALL be ignored.
REQ-025 The block SHALL hold at most one outstanding grant.
- gnt, rsp_done and rsp_err SHALL each be zero or one-hot at all times.

Reset
REQ-026 Asserting reset (low) SHALL immediately force:
- state=IDLE, ptr=0, owner=0, counter=0;
- gnt=0, rsp_done=0, rsp_err=0, eng_start=0, eng_seed=0, eng_nonce=0.
REQ-027 Reset asserted mid-BUSY SHALL abandon the grant without any rsp pulse.
REQ-028 After reset deassertion, arbitration SHALL restart from index 0.

Structure
REQ-029 SEED_W=256, NONCE_W=16, POLY_W=8192 and the default TIMEOUT SHALL live in the shared Dilithium parameter package.
REQ-030 The round-robin pick SHALL be a separate combinational sub-module rr_arbiter (inputs req and ptr; outputs a one-hot grant and its index).

Verification
REQ-031 Single request: req=3'b010 with nonce 0x0103 -> eng_start and gnt=3'b010 one cycle later, eng_nonce=0x0103; eng_done at BUSY cycle 50 -> rsp_done=3'b010 one cycle, then eng_start low for 1 cycle.
REQ-032 Contention: req=3'b111 held through three grants, ptr=0 -> grant order 0,1,2, then 0 again; each eng_start deasserted ≥1 cycle between grants.
REQ-033 Timeout: TIMEOUT=16, req=3'b001, eng_done never asserted -> rsp_err=3'b001 after 16 BUSY cycles, no rsp_done, FSM back to IDLE.
REQ-034 Simultaneous events: eng_done asserted in the timeout cycle -> rsp_done only; req dropped during BUSY -> rsp_done still pulses.
REQ-035 Reset mid-BUSY: reset low at BUSY cycle 10 -> all outputs 0 asynchronously, no rsp pulse; after release, req=3'b100 -> grant to index 2 with ptr starting at 0.
REQ-036 Matrix expansion sweep: one requester issues 30 nonces (i<<8)+j for i<6, j<5 -> 30 rsp_done pulses in order, eng_nonce matching each request.

Source files
------------

// File: rtl/sampler_arbiter_pkg.sv
// Shared Dilithium sampler parameters and the arbiter state encoding.
package sampler_arbiter_pkg;

    localparam int SEED_W      = 256;
    localparam int NONCE_W     = 16;
    localparam int POLY_W      = 8192;
    localparam int TIMEOUT_DEF = 4096;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY    = 2'd1,
        ST_RELEASE = 2'd2
    } arb_state_e;

endpackage

// File: rtl/sampler_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr, wrapping.
module rr_arbiter #(
    parameter int NREQ  = 3,
    parameter int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [NREQ-1:0]  gnt,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    // Walk the candidates in priority order starting from ptr.
    always_comb begin
        logic [IDX_W-1:0] cand_s;
        gnt    = {NREQ{1'b0}};
        idx    = {IDX_W{1'b0}};
        valid  = 1'b0;
        cand_s = {IDX_W{1'b0}};
        for (int i = 0; i < NREQ; i++) begin
            cand_s = IDX_W'((int'(ptr) + i) % NREQ);
            if (!valid && req[cand_s]) begin
                valid       = 1'b1;
                idx         = cand_s;
                gnt[cand_s] = 1'b1;
            end else begin
                valid = valid;
            end
        end
    end

endmodule

// File: rtl/sampler_arbiter.sv
// Shares one poly_uniform engine among NREQ requesters: round-robin grant,
// latched seed/nonce, done/timeout responses and a one-cycle re-arm gap.
module sampler_arbiter
    import sampler_arbiter_pkg::*;
#(
    parameter int NREQ    = 3,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NREQ-1:0]           req,
    input  logic [SEED_W*NREQ-1:0]    req_seed,
    input  logic [NONCE_W*NREQ-1:0]   req_nonce,
    output logic [NREQ-1:0]           gnt,
    output logic [NREQ-1:0]           rsp_done,
    output logic [NREQ-1:0]           rsp_err,
    output logic                      eng_start,
    output logic [SEED_W-1:0]         eng_seed,
    output logic [NONCE_W-1:0]        eng_nonce,
    input  logic                      eng_done
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NREQ - 1);

    arb_state_e         state_r;
    logic [IDX_W-1:0]   ptr_r;
    logic [IDX_W-1:0]   owner_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [NREQ-1:0]    gnt_r;
    logic [NREQ-1:0]    rsp_done_r;
    logic [NREQ-1:0]    rsp_err_r;
    logic               eng_start_r;
    logic [SEED_W-1:0]  eng_seed_r;
    logic [NONCE_W-1:0] eng_nonce_r;

    logic [NREQ-1:0]    win_gnt_s;
    logic [IDX_W-1:0]   win_idx_s;
    logic               win_valid_s;
    logic [IDX_W-1:0]   next_ptr_s;
    logic [NREQ-1:0]    owner_oh_s;
    logic [SEED_W-1:0]  seed_arr_s  [NREQ];
    logic [NONCE_W-1:0] nonce_arr_s [NREQ];

    for (genvar k = 0; k < NREQ; k++) begin : g_slice
        assign seed_arr_s[k]  = req_seed[k*SEED_W +: SEED_W];
        assign nonce_arr_s[k] = req_nonce[k*NONCE_W +: NONCE_W];
    end

    rr_arbiter #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_rr (
        .req   (req),
        .ptr   (ptr_r),
        .gnt   (win_gnt_s),
        .idx   (win_idx_s),
        .valid (win_valid_s)
    );

    assign next_ptr_s = (win_idx_s == IDX_LAST) ? {IDX_W{1'b0}} : win_idx_s + IDX_W'(1);

    // One-hot of the latched owner, used to steer the response pulses.
    always_comb begin
        owner_oh_s = {NREQ{1'b0}};
        for (int i = 0; i < NREQ; i++) begin
            owner_oh_s[i] = (owner_r == IDX_W'(i));
        end
    end

    // Arbiter FSM with all outputs registered; response pulses self-clear.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            ptr_r       <= {IDX_W{1'b0}};
            owner_r     <= {IDX_W{1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
            gnt_r       <= {NREQ{1'b0}};
            rsp_done_r  <= {NREQ{1'b0}};
            rsp_err_r   <= {NREQ{1'b0}};
            eng_start_r <= 1'b0;
            eng_seed_r  <= {SEED_W{1'b0}};
            eng_nonce_r <= {NONCE_W{1'b0}};
        end else begin
            rsp_done_r <= {NREQ{1'b0}};
            rsp_err_r  <= {NREQ{1'b0}};
            case (state_r)
                ST_IDLE: begin
                    if (win_valid_s) begin
                        owner_r     <= win_idx_s;
                        gnt_r       <= win_gnt_s;
                        eng_seed_r  <= seed_arr_s[win_idx_s];
                        eng_nonce_r <= nonce_arr_s[win_idx_s];
                        eng_start_r <= 1'b1;
                        cnt_r       <= {CNT_W{1'b0}};
                        ptr_r       <= next_ptr_s;
                        state_r     <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    // Done takes priority over a timeout landing in the same cycle.
                    if (eng_done) begin
                        rsp_done_r  <= owner_oh_s;
                        gnt_r       <= {NREQ{1'b0}};
                        eng_start_r <= 1'b0;
                        state_r     <= ST_RELEASE;
                    end else if (cnt_r == CNT_LAST) begin
                        rsp_err_r   <= owner_oh_s;
                        gnt_r       <= {NREQ{1'b0}};
                        eng_start_r <= 1'b0;
                        state_r     <= ST_RELEASE;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                ST_RELEASE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r     <= ST_IDLE;
                    gnt_r       <= {NREQ{1'b0}};
                    eng_start_r <= 1'b0;
                end
            endcase
        end
    end

    assign gnt       = gnt_r;
    assign rsp_done  = rsp_done_r;
    assign rsp_err   = rsp_err_r;
    assign eng_start = eng_start_r;
    assign eng_seed  = eng_seed_r;
    assign eng_nonce = eng_nonce_r;

endmodule

// File: tb/tb_sampler_arbiter.sv
// Directed bench: instance a uses the default TIMEOUT, instance b uses TIMEOUT=16.
module tb_sampler_arbiter;
    import sampler_arbiter_pkg::*;

    localparam int NREQ = 3;
    localparam logic [SEED_W-1:0] SEED0 = {8{32'h5EED_0A0A}};
    localparam logic [SEED_W-1:0] SEED1 = {8{32'h1111_2222}};
    localparam logic [SEED_W-1:0] SEEDX = {8{32'hDEAD_BEEF}};

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic [NREQ-1:0]         req_a = '0;
    logic [NREQ-1:0]         req_b = '0;
    logic [SEED_W*NREQ-1:0]  req_seed = '0;
    logic [NONCE_W*NREQ-1:0] req_nonce = '0;
    logic eng_done_a = 1'b0;
    logic eng_done_b = 1'b0;

    logic [NREQ-1:0]    gnt_a, rsp_done_a, rsp_err_a;
    logic [NREQ-1:0]    gnt_b, rsp_done_b, rsp_err_b;
    logic               eng_start_a, eng_start_b;
    logic [SEED_W-1:0]  eng_seed_a, eng_seed_b;
    logic [NONCE_W-1:0] eng_nonce_a, eng_nonce_b;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    logic [NONCE_W-1:0] nonce;
    logic [NREQ-1:0]    oh;

    sampler_arbiter #(.NREQ(NREQ)) dut_a (
        .clock(clock), .reset(reset), .req(req_a), .req_seed(req_seed),
        .req_nonce(req_nonce), .gnt(gnt_a), .rsp_done(rsp_done_a),
        .rsp_err(rsp_err_a), .eng_start(eng_start_a), .eng_seed(eng_seed_a),
        .eng_nonce(eng_nonce_a), .eng_done(eng_done_a)
    );

    sampler_arbiter #(.NREQ(NREQ), .TIMEOUT(16)) dut_b (
        .clock(clock), .reset(reset), .req(req_b), .req_seed(req_seed),
        .req_nonce(req_nonce), .gnt(gnt_b), .rsp_done(rsp_done_b),
        .rsp_err(rsp_err_b), .eng_start(eng_start_b), .eng_seed(eng_seed_b),
        .eng_nonce(eng_nonce_b), .eng_done(eng_done_b)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        chk(tag, 256'(obs), 256'(exp));
    endtask

    task automatic chkn(input string tag, input logic [NREQ-1:0] obs, input logic [NREQ-1:0] exp);
        chk(tag, 256'(obs), 256'(exp));
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        chk(tag, 256'(obs), 256'(exp));
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk(tag, 256'(obs), 256'(exp));
    endtask

    initial begin
        // Reset values
        #1 reset = 1'b0;
        #1;
        chkn("rst_gnt", gnt_a, 3'b000);
        chk1("rst_start", eng_start_a, 1'b0);
        chk("rst_seed", eng_seed_a, 256'd0);
        chk16("rst_nonce", eng_nonce_a, 16'h0000);
        chkn("rst_done", rsp_done_a, 3'b000);
        chkn("rst_err", rsp_err_a, 3'b000);
        tick();
        tick();
        reset = 1'b1;
        tick();

        // Timeout on instance b (TIMEOUT=16)
        req_seed[0 +: SEED_W] = SEED0;
        req_b = 3'b001;
        tick();
        chkn("to_gnt", gnt_b, 3'b001);
        chk1("to_start", eng_start_b, 1'b1);
        for (int c = 1; c < 16; c++) begin
            tick();
            chkn("to_no_err_early", rsp_err_b, 3'b000);
        end
        chk1("to_start_held", eng_start_b, 1'b1);
        tick();
        chkn("to_err", rsp_err_b, 3'b001);
        chkn("to_no_done", rsp_done_b, 3'b000);
        chkn("to_gnt_clr", gnt_b, 3'b000);
        chk1("to_start_low", eng_start_b, 1'b0);
        req_b = 3'b000;
        tick();
        chkn("to_err_pulse", rsp_err_b, 3'b000);
        tick();

        // Done in the timeout cycle wins
        req_b = 3'b001;
        tick();
        chkn("sim_gnt", gnt_b, 3'b001);
        repeat (15) tick();
        eng_done_b = 1'b1;
        tick();
        chkn("sim_done", rsp_done_b, 3'b001);
        chkn("sim_no_err", rsp_err_b, 3'b000);
        eng_done_b = 1'b0;
        req_b = 3'b000;
        tick();
        tick();

        // Single request, done at BUSY cycle 50
        req_seed[SEED_W +: SEED_W]    = SEED1;
        req_nonce[NONCE_W +: NONCE_W] = 16'h0103;
        req_a = 3'b010;
        tick();
        chkn("one_gnt", gnt_a, 3'b010);
        chk1("one_start", eng_start_a, 1'b1);
        chk16("one_nonce", eng_nonce_a, 16'h0103);
        chk("one_seed", eng_seed_a, SEED1);
        for (int c = 1; c <= 50; c++) begin
            if (c == 20) begin
                req_seed[SEED_W +: SEED_W]    = SEEDX;
                req_nonce[NONCE_W +: NONCE_W] = 16'hBEEF;
            end
            tick();
            chk1("one_busy_start", eng_start_a, 1'b1);
            chkn("one_busy_nodone", rsp_done_a, 3'b000);
        end
        chk("one_seed_stable", eng_seed_a, SEED1);
        chk16("one_nonce_stable", eng_nonce_a, 16'h0103);
        eng_done_a = 1'b1;
        tick();
        chkn("one_done", rsp_done_a, 3'b010);
        chk1("one_start_drop", eng_start_a, 1'b0);
        chkn("one_gnt_clr", gnt_a, 3'b000);
        eng_done_a = 1'b0;
        req_a = 3'b000;
        tick();
        chkn("one_done_pulse", rsp_done_a, 3'b000);
        chk1("one_release_low", eng_start_a, 1'b0);
        tick();

        // Reset mid-BUSY on both instances
        req_a = 3'b001;
        req_b = 3'b001;
        tick();
        chkn("rb_gnt_a", gnt_a, 3'b001);
        chkn("rb_gnt_b", gnt_b, 3'b001);
        repeat (10) tick();
        reset = 1'b0;
        #1;
        chkn("rb_async_gnt", gnt_a, 3'b000);
        chk1("rb_async_start", eng_start_a, 1'b0);
        chk("rb_async_seed", eng_seed_a, 256'd0);
        chk16("rb_async_nonce", eng_nonce_a, 16'h0000);
        chkn("rb_async_gnt_b", gnt_b, 3'b000);
        chk1("rb_async_start_b", eng_start_b, 1'b0);
        tick();
        chkn("rb_no_done", rsp_done_a, 3'b000);
        chkn("rb_no_err", rsp_err_a, 3'b000);
        reset = 1'b1;
        req_a = 3'b100;
        req_b = 3'b011;
        tick();
        chkn("rb_regrant_a", gnt_a, 3'b100);
        chk1("rb_regrant_start", eng_start_a, 1'b1);
        chkn("rb_ptr0_b", gnt_b, 3'b001);
        eng_done_a = 1'b1;
        eng_done_b = 1'b1;
        tick();
        chkn("rb_done_a", rsp_done_a, 3'b100);
        chkn("rb_done_b", rsp_done_b, 3'b001);
        eng_done_a = 1'b0;
        eng_done_b = 1'b0;
        req_a = 3'b000;
        req_b = 3'b000;
        tick();
        tick();

        // Contention with all requests held, ptr=0: order 0,1,2,0
        req_a = 3'b111;
        for (int k = 0; k < 4; k++) begin
            oh = 3'b001 << (k % 3);
            tick();
            chkn("rr_gnt", gnt_a, oh);
            chk1("rr_start", eng_start_a, 1'b1);
            tick();
            tick();
            eng_done_a = 1'b1;
            tick();
            chkn("rr_done", rsp_done_a, oh);
            eng_done_a = 1'b0;
            tick();
            chk1("rr_gap_start", eng_start_a, 1'b0);
            chkn("rr_gap_done", rsp_done_a, 3'b000);
        end
        req_a = 3'b000;

        // eng_done while idle is ignored
        eng_done_a = 1'b1;
        tick();
        chkn("idle_done_ign", rsp_done_a, 3'b000);
        chk1("idle_no_start", eng_start_a, 1'b0);
        eng_done_a = 1'b0;

        // Owner drops req during BUSY
        req_a = 3'b010;
        tick();
        chkn("drop_gnt", gnt_a, 3'b010);
        req_a = 3'b000;
        tick();
        tick();
        chkn("drop_gnt_held", gnt_a, 3'b010);
        eng_done_a = 1'b1;
        tick();
        chkn("drop_done", rsp_done_a, 3'b010);
        eng_done_a = 1'b0;
        tick();

        // Matrix expansion sweep from requester 2
        for (int i = 0; i < 6; i++) begin
            for (int j = 0; j < 5; j++) begin
                nonce = 16'((i << 8) + j);
                req_nonce[2*NONCE_W +: NONCE_W] = nonce;
                req_a = 3'b100;
                tick();
                chk16("sweep_nonce", eng_nonce_a, nonce);
                tick();
                eng_done_a = 1'b1;
                tick();
                chkn("sweep_done", rsp_done_a, 3'b100);
                if (rsp_done_a == 3'b100) begin
                    done_cnt++;
                end
                eng_done_a = 1'b0;
                req_a = 3'b000;
                tick();
            end
        end
        chk32("sweep_count", 32'(done_cnt), 32'd30);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
